// File: rtl/friscv_pkg.sv
// Shared types and constants for the load/store unit data path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package friscv_pkg;

    // RISC-V major opcodes handled by the LSU
    localparam logic [6:0] IMM_LOAD = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_t;

    // Access size in bytes (1, 2, 4 or 8)
    function automatic logic [3:0] size_bytes(input lsu_size_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_data_align_lane.sv
// Lane steering: byte enables / shifted store data for both beats, load assemble + extend.
// Latency: purely combinational.
// Backpressure: none; the owning FSM holds inputs stable while outputs are in use.
// Ports: i_off byte offset in bus word; i_size/i_unsigned access size and extension;
//        i_split load spans two beats; i_st_data right-aligned store data;
//        i_rdata0/1 beat read data; o_be0/1, o_wdata0/1 beat payloads; o_ld_data result.
module lsu_lane_align
    import friscv_pkg::*;
#(
    parameter  int ARCH = 32,
    localparam int NB   = ARCH / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0] i_off,
    input  lsu_size_t       i_size,
    input  logic            i_unsigned,
    input  logic            i_split,
    input  logic [ARCH-1:0] i_st_data,
    input  logic [ARCH-1:0] i_rdata0,
    input  logic [ARCH-1:0] i_rdata1,
    output logic [NB-1:0]   o_be0,
    output logic [NB-1:0]   o_be1,
    output logic [ARCH-1:0] o_wdata0,
    output logic [ARCH-1:0] o_wdata1,
    output logic [ARCH-1:0] o_ld_data
);

    logic [3:0]      w_bytes;
    logic [NB-1:0]   w_mask;
    logic [ARCH-1:0] w_keep;
    logic [ARCH-1:0] w_raw;
    logic [ARCH-1:0] w_r1;
    logic            w_sign;
    logic [OFFW+2:0] w_sh;     // bit shift for beat 0: 8*off
    logic [OFFW+3:0] w_rsh;    // bit shift for beat 1: 8*(NB-off)
    logic [OFFW:0]   w_brsh;   // byte-enable shift for beat 1: NB-off

    assign w_sh   = {i_off, 3'b000};
    assign w_rsh  = (OFFW+4)'(ARCH) - (OFFW+4)'(w_sh);
    assign w_brsh = (OFFW+1)'(NB) - (OFFW+1)'(i_off);

    // A shift by the full width yields zero, so off=0 gives empty beat-1 payloads.
    assign o_be0    = w_mask << i_off;
    assign o_be1    = w_mask >> w_brsh;
    assign o_wdata0 = i_st_data << w_sh;
    assign o_wdata1 = i_st_data >> w_rsh;

    assign w_r1  = i_split ? i_rdata1 : '0;
    assign w_raw = (i_rdata0 >> w_sh) | (w_r1 << w_rsh);

    always_comb begin
        w_bytes = size_bytes(i_size);
        // A doubleword on a 32-bit bus is rejected upstream; clamp so indexing stays in range.
        if (w_bytes > 4'(NB)) begin
            w_bytes = 4'(NB);
        end
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < int'(w_bytes));
        end
        w_keep = '0;
        w_sign = 1'b0;
        for (int i = 0; i < ARCH; i++) begin
            w_keep[i] = (i < 8 * int'(w_bytes));
            if (i == 8 * int'(w_bytes) - 1) begin
                w_sign = w_raw[i];
            end
        end
        o_ld_data = (w_raw & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);
    end

endmodule

// File: rtl/lsu_data_align.sv
// Load/store data path: one core access -> one or two memory beats -> extended result.
// Latency: aligned access 3 cycles accept-to-rsp_valid_out with a 1-cycle memory; split adds 2; errors 1.
// Backpressure: req_ready_out only in IDLE; beat payload held stable until mem_req_ready_in.
// Ports: core side req_valid_in/req_ready_out, op_code_in, func3_in, addr_in, st_data_in,
//        rsp_valid_out, ld_data_out, err_out; memory side mem_req_valid_out/mem_req_ready_in,
//        mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out, mem_rsp_valid_in, mem_rdata_in.
module lsu_data_align
    import friscv_pkg::*;
#(
    parameter  int ARCH        = 32,
    parameter  bit MISALIGN_EN = 1'b1,
    localparam int NB          = ARCH / 8,
    localparam int OFFW        = $clog2(NB)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [6:0]      op_code_in,
    input  logic [2:0]      func3_in,
    input  logic [ARCH-1:0] addr_in,
    input  logic [ARCH-1:0] st_data_in,
    output logic            rsp_valid_out,
    output logic [ARCH-1:0] ld_data_out,
    output logic            err_out,
    output logic            mem_req_valid_out,
    input  logic            mem_req_ready_in,
    output logic            mem_we_out,
    output logic [ARCH-1:0] mem_addr_out,
    output logic [NB-1:0]   mem_be_out,
    output logic [ARCH-1:0] mem_wdata_out,
    input  logic            mem_rsp_valid_in,
    input  logic [ARCH-1:0] mem_rdata_in
);

    lsu_state_t      r_state;
    logic            r_is_store;
    lsu_size_t       r_size;
    logic            r_unsigned;
    logic [OFFW-1:0] r_off;
    logic            r_split;
    logic [ARCH-1:0] r_addr_al;
    logic [ARCH-1:0] r_st_data;
    logic [ARCH-1:0] r_r0;

    logic            w_idle;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_illegal;
    logic            w_cross;
    logic [4:0]      w_end;
    lsu_size_t       w_size_in;
    logic [OFFW-1:0] w_off_in;
    logic [ARCH-1:0] w_addr_al;

    lsu_size_t       w_size_sel;
    logic [OFFW-1:0] w_off_sel;
    logic            w_uns_sel;
    logic [ARCH-1:0] w_st_sel;
    logic [ARCH-1:0] w_rdata0;
    logic [NB-1:0]   w_be0;
    logic [NB-1:0]   w_be1;
    logic [ARCH-1:0] w_wdata0;
    logic [ARCH-1:0] w_wdata1;
    logic [ARCH-1:0] w_ld;

    // Request decode, valid only while IDLE
    assign w_idle     = (r_state == ST_IDLE);
    assign w_is_load  = (op_code_in == IMM_LOAD);
    assign w_is_store = (op_code_in == STORE);
    assign w_size_in  = lsu_size_t'(func3_in[1:0]);
    assign w_off_in   = addr_in[OFFW-1:0];
    assign w_addr_al  = addr_in & ~ARCH'(NB - 1);
    assign w_illegal  = !(w_is_load || w_is_store)
                      || (w_is_store && func3_in[2])
                      || ((ARCH == 32) && (w_size_in == SZ_D));
    assign w_end      = 5'(w_off_in) + 5'(size_bytes(w_size_in));
    assign w_cross    = (w_end > 5'(NB));

    // Beat 0 is launched from the live request in IDLE; everything later uses latched copies.
    assign w_size_sel = w_idle ? w_size_in   : r_size;
    assign w_off_sel  = w_idle ? w_off_in    : r_off;
    assign w_uns_sel  = w_idle ? func3_in[2] : r_unsigned;
    assign w_st_sel   = w_idle ? st_data_in  : r_st_data;
    // Completion in RSP0 uses the live beat; in RSP1 beat 0 comes from r_r0.
    assign w_rdata0   = (r_state == ST_RSP0) ? mem_rdata_in : r_r0;

    lsu_lane_align #(.ARCH(ARCH)) u_lane (
        .i_off      (w_off_sel),
        .i_size     (w_size_sel),
        .i_unsigned (w_uns_sel),
        .i_split    (r_split),
        .i_st_data  (w_st_sel),
        .i_rdata0   (w_rdata0),
        .i_rdata1   (mem_rdata_in),
        .o_be0      (w_be0),
        .o_be1      (w_be1),
        .o_wdata0   (w_wdata0),
        .o_wdata1   (w_wdata1),
        .o_ld_data  (w_ld)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state           <= ST_IDLE;
            r_is_store        <= 1'b0;
            r_size            <= SZ_B;
            r_unsigned        <= 1'b0;
            r_off             <= '0;
            r_split           <= 1'b0;
            r_addr_al         <= '0;
            r_st_data         <= '0;
            r_r0              <= '0;
            req_ready_out     <= 1'b1;
            rsp_valid_out     <= 1'b0;
            err_out           <= 1'b0;
            ld_data_out       <= '0;
            mem_req_valid_out <= 1'b0;
            mem_we_out        <= 1'b0;
            mem_addr_out      <= '0;
            mem_be_out        <= '0;
            mem_wdata_out     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_in && req_ready_out) begin
                        req_ready_out <= 1'b0;
                        r_is_store    <= w_is_store;
                        r_size        <= w_size_in;
                        r_unsigned    <= func3_in[2];
                        r_off         <= w_off_in;
                        r_split       <= w_cross;
                        r_addr_al     <= w_addr_al;
                        r_st_data     <= st_data_in;
                        if (w_illegal || (w_cross && !MISALIGN_EN)) begin
                            r_state       <= ST_DONE;
                            rsp_valid_out <= 1'b1;
                            err_out       <= 1'b1;
                        end else begin
                            r_state           <= ST_REQ0;
                            mem_req_valid_out <= 1'b1;
                            mem_we_out        <= w_is_store;
                            mem_addr_out      <= w_addr_al;
                            mem_be_out        <= w_be0;
                            mem_wdata_out     <= w_wdata0;
                        end
                    end
                end
                ST_REQ0, ST_REQ1: begin
                    if (mem_req_ready_in) begin
                        mem_req_valid_out <= 1'b0;
                        r_state           <= (r_state == ST_REQ0) ? ST_RSP0 : ST_RSP1;
                    end
                end
                ST_RSP0: begin
                    if (mem_rsp_valid_in) begin
                        r_r0 <= mem_rdata_in;
                        if (r_split) begin
                            r_state           <= ST_REQ1;
                            mem_req_valid_out <= 1'b1;
                            mem_addr_out      <= r_addr_al + ARCH'(NB);
                            mem_be_out        <= w_be1;
                            mem_wdata_out     <= w_wdata1;
                        end else begin
                            r_state       <= ST_DONE;
                            rsp_valid_out <= 1'b1;
                            err_out       <= 1'b0;
                            if (!r_is_store) begin
                                ld_data_out <= w_ld;
                            end
                        end
                    end
                end
                ST_RSP1: begin
                    if (mem_rsp_valid_in) begin
                        r_state       <= ST_DONE;
                        rsp_valid_out <= 1'b1;
                        err_out       <= 1'b0;
                        if (!r_is_store) begin
                            ld_data_out <= w_ld;
                        end
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    rsp_valid_out <= 1'b0;
                    err_out       <= 1'b0;
                    req_ready_out <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    req_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
